// File: rtl/bch_syndrome_sequencer.sv
// Bit-serial front end for a bank of Horner-style BCH syndrome units. It counts N
// accepted codeword bits, drives the bank's start/ce/data controls, and hands the
// finished syndrome vector to the locator stage through a one-entry valid/ready slot.
module bch_syndrome_sequencer #(
    parameter int M    = 4,
    parameter int NSYN = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_data,
    input  logic              abort,
    output logic              syn_start,
    output logic              syn_ce,
    output logic              syn_data,
    input  logic [NSYN*M-1:0] syn_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NSYN*M-1:0] out_syn,
    output logic              out_zero,
    output logic              busy
);

    localparam int N  = (2 ** M) - 1;
    localparam int CW = $clog2(N);

    typedef enum logic {
        FILL,
        CAPTURE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          acc;
    logic          last_bit;
    logic          slot_free;
    logic          capture;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        in_ready   = (state == FILL) & ~abort & ~reset;
        acc        = in_valid & in_ready;
        last_bit   = (cnt == CW'(N - 1));
        syn_start  = acc & (cnt == '0);
        syn_ce     = acc & (cnt != '0);
        syn_data   = in_data;
        slot_free  = ~out_valid | out_ready;
        capture    = (state == CAPTURE) & slot_free;
        state_next = state;
        cnt_next   = cnt;
        case (state)
            FILL: begin
                if (abort) begin
                    cnt_next = '0;
                end else if (acc) begin
                    if (last_bit) begin
                        cnt_next   = '0;
                        state_next = CAPTURE;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
            end
            CAPTURE: begin
                // Bank is frozen here: no start/ce can be issued while not in FILL.
                if (slot_free) state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_syn   <= '0;
            out_zero  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                out_syn   <= syn_in;
                out_zero  <= (syn_in == '0);
                out_valid <= 1'b1;
            end else if (out_valid & out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (cnt != '0) | (state == CAPTURE);

endmodule

// File: tb/tb_bch_syndrome_sequencer.sv
// Bench for bch_syndrome_sequencer with a behavioural S1/S3/S5 bank over GF(16)
// (x^4+x+1) and a direct-sum syndrome reference model feeding an output scoreboard.
module tb_bch_syndrome_sequencer;

    localparam int M    = 4;
    localparam int NSYN = 3;
    localparam int N    = 15;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic              in_data;
    logic              abort;
    logic              syn_start;
    logic              syn_ce;
    logic              syn_data;
    logic [NSYN*M-1:0] syn_in;
    logic              out_valid;
    logic              out_ready;
    logic [NSYN*M-1:0] out_syn;
    logic              out_zero;
    logic              busy;

    bch_syndrome_sequencer #(.M(M), .NSYN(NSYN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
        .syn_start (syn_start),
        .syn_ce    (syn_ce),
        .syn_data  (syn_data),
        .syn_in    (syn_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_syn   (out_syn),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int tb_idx  = 0;
    bit rand_mode = 0;
    logic [NSYN*M-1:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // GF(16) helpers, primitive polynomial x^4 + x + 1
    function automatic logic [3:0] xtime(input logic [3:0] a);
        return a[3] ? ({a[2:0], 1'b0} ^ 4'h3) : {a[2:0], 1'b0};
    endfunction

    function automatic logic [3:0] apow(input int e);
        logic [3:0] r = 4'h1;
        for (int i = 0; i < e % N; i++) r = xtime(r);
        return r;
    endfunction

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r = 4'h0;
        logic [3:0] t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r ^= t;
            t = xtime(t);
        end
        return r;
    endfunction

    // Reference: S_j = sum over set bits r_i of alpha^(i*j), j = 1, 3, 5
    function automatic logic [NSYN*M-1:0] ref_syn(input logic [N-1:0] cw);
        logic [NSYN*M-1:0] r = '0;
        for (int j = 0; j < NSYN; j++) begin
            logic [3:0] s = 4'h0;
            for (int i = 0; i < N; i++)
                if (cw[i]) s ^= apow((i * (2 * j + 1)) % N);
            r[4*j +: 4] = s;
        end
        return r;
    endfunction

    // Bank of Horner accumulators driven by the sequencer
    logic [3:0] bank [0:NSYN-1];
    always @(posedge clk) begin
        for (int j = 0; j < NSYN; j++) begin
            if (syn_start)   bank[j] <= {3'b000, syn_data};
            else if (syn_ce) bank[j] <= gf_mul(bank[j], apow(2 * j + 1)) ^ {3'b000, syn_data};
        end
    end
    assign syn_in = {bank[2], bank[1], bank[0]};

    // Scoreboard: every output transfer must match the next expected word in order
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 16'(out_valid), 16'd0);
            end else begin
                logic [NSYN*M-1:0] e;
                e = exp_q.pop_front();
                check("sb_out_syn", 16'(out_syn), 16'(e));
                check("sb_out_zero", 16'(out_zero), 16'(e == '0));
            end
        end
    end

    task automatic drive_bit(input logic b, output int waits);
        bit done = 0;
        waits = 0;
        if (rand_mode && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!done) begin
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                check("syn_start", 16'(syn_start), 16'(tb_idx == 0));
                check("syn_ce", 16'(syn_ce), 16'(tb_idx != 0));
                check("syn_data", 16'(syn_data), 16'(b));
                @(posedge clk); #1;
                tb_idx = (tb_idx == N - 1) ? 0 : tb_idx + 1;
                done = 1;
            end else begin
                if (syn_start || syn_ce) check("ctl_while_stalled", 16'({syn_start, syn_ce}), 16'd0);
                @(posedge clk); #1;
                waits++;
                if (waits > 40) begin
                    check("accept_timeout", 16'(waits), 16'd0);
                    done = 1;
                end
            end
        end
    endtask

    task automatic send_word(input logic [N-1:0] cw, input bit keep, output int first_wait);
        int w;
        exp_q.push_back(ref_syn(cw));
        for (int k = 0; k < N; k++) begin
            drive_bit(cw[N-1-k], w);
            if (k == 0) first_wait = w;
        end
        if (!keep) in_valid = 1'b0;
    endtask

    // Called right after the last accept edge with the output slot free
    task automatic wait_capture(input logic [NSYN*M-1:0] exp);
        @(negedge clk);
        check("capture_in_ready", 16'(in_ready), 16'd0);
        check("capture_busy", 16'(busy), 16'd1);
        @(posedge clk); #1;
        check("cap_out_valid", 16'(out_valid), 16'd1);
        check("cap_out_syn", 16'(out_syn), 16'(exp));
        check("cap_out_zero", 16'(out_zero), 16'(exp == '0));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 16'(out_valid), 16'd0);
        check({tag, "_out_syn"}, 16'(out_syn), 16'd0);
        check({tag, "_out_zero"}, 16'(out_zero), 16'd0);
        check({tag, "_busy"}, 16'(busy), 16'd0);
    endtask

    typedef struct {
        logic [N-1:0]      cw;
        logic [NSYN*M-1:0] syn;
        logic              zero;
    } vec_t;

    vec_t vecs[6];
    int   fw;
    int   guard;

    initial begin
        vecs[0] = '{15'h0000, 12'h000, 1'b1};  // error-free
        vecs[1] = '{15'h0001, 12'h111, 1'b0};  // error at r_0
        vecs[2] = '{15'h4000, 12'h7F9, 1'b0};  // error at r_14
        vecs[3] = '{15'h0002, 12'h682, 1'b0};  // error at r_1
        vecs[4] = '{15'h4001, 12'h6E8, 1'b0};  // errors at r_0 and r_14
        vecs[5] = '{15'h7FFF, 12'h000, 1'b1};  // all-ones is a codeword

        reset = 1'b1; in_valid = 1'b0; in_data = 1'b0; abort = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("in_ready_in_reset", 16'(in_ready), 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("rst");
        check("rst_in_ready", 16'(in_ready), 16'd1);
        @(posedge clk); #1;

        // All-zero words with in_valid held: one-cycle capture, single ready bubble
        send_word(15'h0000, 1, fw);
        wait_capture(12'h000);
        send_word(15'h0000, 0, fw);
        check("ready_bubble_len", 16'(fw), 16'd0);
        wait_capture(12'h000);

        foreach (vecs[v]) begin
            send_word(vecs[v].cw, 0, fw);
            @(negedge clk);
            check("tbl_in_ready", 16'(in_ready), 16'd0);
            @(posedge clk); #1;
            check("tbl_out_valid", 16'(out_valid), 16'd1);
            check("tbl_out_syn", 16'(out_syn), 16'(vecs[v].syn));
            check("tbl_out_zero", 16'(out_zero), 16'(vecs[v].zero));
        end
        @(posedge clk); #1;

        // Back-to-back with the slot blocked during the second capture
        out_ready = 1'b0;
        send_word(15'h0001, 1, fw);
        send_word(15'h4000, 1, fw);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_in_ready", 16'(in_ready), 16'd0);
            check("stall_ctl", 16'({syn_start, syn_ce}), 16'd0);
            check("stall_out_valid", 16'(out_valid), 16'd1);
            check("stall_hold_syn", 16'(out_syn), 16'h111);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("nobubble_valid", 16'(out_valid), 16'd1);
        check("nobubble_syn", 16'(out_syn), 16'h7F9);
        @(posedge clk); #1;

        // Abort after 7 bits, then a clean r_14 word
        for (int k = 0; k < 7; k++) drive_bit(1'($urandom_range(0, 1)), fw);
        in_valid = 1'b0;
        abort    = 1'b1;
        @(negedge clk);
        check("abort_in_ready", 16'(in_ready), 16'd0);
        check("abort_ctl", 16'({syn_start, syn_ce}), 16'd0);
        check("abort_busy_before", 16'(busy), 16'd1);
        @(posedge clk); #1;
        abort  = 1'b0;
        tb_idx = 0;
        @(negedge clk);
        check("abort_busy_after", 16'(busy), 16'd0);
        @(posedge clk); #1;
        send_word(15'h4000, 0, fw);
        wait_capture(12'h7F9);

        // abort together with in_valid, at cnt 0 and at cnt 3
        for (int p = 0; p < 2; p++) begin
            if (p == 1) for (int k = 0; k < 3; k++) drive_bit(1'b1, fw);
            in_valid = 1'b1; in_data = 1'b1; abort = 1'b1;
            @(negedge clk);
            check("abort_iv_ready", 16'(in_ready), 16'd0);
            check("abort_iv_ctl", 16'({syn_start, syn_ce}), 16'd0);
            @(posedge clk); #1;
            abort = 1'b0; in_valid = 1'b0; tb_idx = 0;
            @(negedge clk);
            check("abort_iv_busy", 16'(busy), 16'd0);
            @(posedge clk); #1;
        end

        // abort during CAPTURE is ignored
        send_word(15'h0002, 0, fw);
        abort = 1'b1;
        wait_capture(12'h682);
        abort = 1'b0;
        @(posedge clk); #1;

        // reset at cnt 9
        for (int k = 0; k < 9; k++) drive_bit(1'b1, fw);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("rst9_in_ready", 16'(in_ready), 16'd0);
        @(posedge clk); #1;
        reset  = 1'b0;
        tb_idx = 0;
        check_reset_state("rst9");

        // reset while out_valid is held
        out_ready = 1'b0;
        send_word(15'h0001, 0, fw);
        wait_capture(12'h111);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        check_reset_state("rstov");
        out_ready = 1'b1;
        send_word(15'h4001, 0, fw);
        wait_capture(12'h6E8);

        // Randomized words, gaps and backpressure against the reference model
        rand_mode = 1;
        for (int r = 0; r < 25; r++) send_word(N'($urandom), 0, fw);
        rand_mode = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_queue", 16'(exp_q.size()), 16'd0);
        check("drain_valid", 16'(out_valid), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
